game_referee: RTL
=================

# game_referee

Per-player survival referee for the gravity game. It consumes the four player vertical positions produced by the player generators and the enabled-player mask from game start, then detects when a player leaves the playfield. It accumulates per-player survival scores in 0.1 s units and declares game over, a winner, or a draw. Its outputs feed the score/winner overlay and the LED status logic in the top level.

## Interface
Parameters:
- TICK_CYCLES, 10_000_000, `clk_i` cycles per score tick (0.1 s at 100 MHz)
- TOP_LIMIT, 0, player `loc` at or below this value eliminates the player
- BOT_LIMIT, 440, player `loc` at or above this value eliminates the player (WINDOW_HEIGHT − PLAYER_HEIGHT)
- SCORE_MAX, 9999, saturation value of each score

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high
- `new_game_i`  in  1  new-game button level; only its rising edge acts
- `active_players_i`  in  4  enabled-player mask from game start
- `loc_i`  in  36  packed player top-edge y positions, 9 bits each; player n at [9n+8:9n]
- `score_sel_i`  in  2  selects the player whose score appears on `score_o`
- `alive_o`  out  4  players still in play
- `score_o`  out  14  registered score of the selected player
- `game_over_o`  out  1  game finished
- `winner_valid_o`  out  1  `winner_o` is meaningful
- `winner_o`  out  2  index of the winning player
- `draw_o`  out  1  all remaining players were eliminated on the same edge

## Operation
- States: IDLE, ARMED, RUNNING, OVER.
- Reset: state goes to IDLE. All outputs are 0. All scores are 0. The tick counter is 0.
- Rising edge of `new_game_i` (registered edge detect) from any state: clear scores, `alive_o`, and all game-over flags, then go to ARMED.
- IDLE: wait for a `new_game_i` edge.
- ARMED: on the first edge where `active_players_i != 0`:
  - latch `alive_o <= active_players_i`
  - latch `started = popcount` of that mask
  - clear the tick counter
  - go to RUNNING
- RUNNING:
  - Elimination: on each clock, `out[n] = alive[n] & (loc_n <= TOP_LIMIT | loc_n >= BOT_LIMIT)`, and `alive_next = alive & ~out`. `active_players_i` is ignored in this state.
  - Score tick: when the tick counter reaches TICK_CYCLES−1, it wraps to 0. On that edge, every player alive *before* elimination on that same edge increments its score, saturating at SCORE_MAX.
  - End condition, multiplayer (`started >= 2`): `popcount(alive_next) <= 1`.
  - End condition, solo (`started == 1`): `alive_next == 0`.
  - On the end condition, go to OVER with:
    - exactly one survivor: `winner_valid_o=1`, `winner_o` = that index
    - zero survivors in multiplayer: `draw_o=1`
    - solo: `winner_valid_o=0` and `draw_o=0`
- OVER: all outputs and scores are frozen until a `new_game_i` edge or `rst_i`.
- `score_o` shows the score of the player selected by `score_sel_i` and is valid in every state.

## Timing
- Output latency:
  - `alive_o`, the game-over flags, and the state change all update on the same edge where `loc_i` first meets a limit (1 cycle latency).
  - `score_o` follows `score_sel_i` or a score change by 1 cycle.
- Simultaneous events:
  - `new_game_i` edge and an elimination on the same cycle: the new game wins.
  - `rst_i` and anything else on the same cycle: reset wins.
- `loc_i` is updated by the slower player clock. The block samples it every `clk_i` cycle. Positions are monotonic between updates, so no extra synchronisation is required.
- Reset mid-RUNNING: next cycle the state is IDLE and all outputs are 0, even if `new_game_i` is held high. The held level is not an edge.

## Structure
- Package `game_pkg`:
  - state enum (IDLE/ARMED/RUNNING/OVER)
  - WINDOW_HEIGHT=480, PLAYER_HEIGHT=40
  - SCORE_W=14, SCORE_MAX
  - NUM_PLAYERS=4
- Sub-module `tick_gen`: parameterised counter with a synchronous clear, producing a one-cycle strobe every TICK_CYCLES.
- Scores: four 14-bit saturating counters in the top of the block, plus a registered read mux.

## Test plan
Benches override TICK_CYCLES=4.
- Reset, then new game with mask 4'b0011, both `loc`=200 → RUNNING, `alive_o`=0011. After 40 cycles both scores = 10.
- Same game, set `loc_0`=440 → next cycle `alive_o`=0010, `game_over_o`=1, `winner_valid_o`=1, `winner_o`=1, `draw_o`=0. Scores then stay frozen.
- Mask 4'b0101, set `loc_0`=0 and `loc_2`=450 on the same cycle → `draw_o`=1, `winner_valid_o`=0, `alive_o`=0000.
- Solo mask 4'b1000 with `loc_3`=200, then run long enough for 10000 ticks → `score_o` (sel=3) saturates at 9999. Then `loc_3`=440 → `game_over_o`=1, `winner_valid_o`=0.
- Assert `rst_i` mid-RUNNING while `new_game_i` is held high → next cycle the state is IDLE and all outputs are 0. Release and re-press `new_game_i` → ARMED.
- In ARMED with `active_players_i`=0 for 100 cycles → stays ARMED with `alive_o`=0. Set mask to 1111 → `alive_o`=1111 on the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game referee
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam int WINDOW_HEIGHT = 480;
  localparam int PLAYER_HEIGHT = 40;
  localparam int SCORE_W       = 14;
  localparam int SCORE_MAX     = 9999;
  localparam int NUM_PLAYERS   = 4;
  localparam int LOC_W         = 9;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running counter emitting a one-cycle strobe every TICK_CYCLES
module tick_gen #(
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_q;

  assign tick_o = en_i & (count_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tick_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/game_referee.sv
// rtl/game_referee.sv - elimination, survival scoring and winner/draw detection
module game_referee #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int TOP_LIMIT   = 0,
  parameter int BOT_LIMIT   = game_pkg::WINDOW_HEIGHT - game_pkg::PLAYER_HEIGHT,
  parameter int SCORE_MAX   = game_pkg::SCORE_MAX
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         new_game_i,
  input  logic [3:0]                   active_players_i,
  input  logic [35:0]                  loc_i,
  input  logic [1:0]                   score_sel_i,
  output logic [3:0]                   alive_o,
  output logic [game_pkg::SCORE_W-1:0] score_o,
  output logic                         game_over_o,
  output logic                         winner_valid_o,
  output logic [1:0]                   winner_o,
  output logic                         draw_o
);

  import game_pkg::*;

  localparam logic [LOC_W-1:0]   TOP_L = LOC_W'(TOP_LIMIT);
  localparam logic [LOC_W-1:0]   BOT_L = LOC_W'(BOT_LIMIT);
  localparam logic [SCORE_W-1:0] SAT   = SCORE_W'(SCORE_MAX);

  state_t             state_q;
  logic [2:0]         started_q;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic               ng_q;
  logic               ng_edge;
  logic               tick;
  logic [3:0]         out_mask;
  logic [3:0]         alive_next;
  logic [2:0]         survivors;
  logic               end_game;
  logic [1:0]         win_idx;

  // No reset here: a button held through reset must not look like a fresh press.
  always_ff @(posedge clk_i) begin
    ng_q <= new_game_i;
  end

  assign ng_edge = new_game_i & ~ng_q;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != ST_RUNNING),
    .en_i  (state_q == ST_RUNNING),
    .tick_o(tick)
  );

  always_comb begin
    out_mask = '0;
    win_idx  = '0;
    for (int n = 0; n < NUM_PLAYERS; n++) begin
      out_mask[n] = alive_o[n] & ((loc_i[LOC_W*n +: LOC_W] <= TOP_L) ||
                                  (loc_i[LOC_W*n +: LOC_W] >= BOT_L));
    end
    alive_next = alive_o & ~out_mask;
    survivors  = popcount4(alive_next);
    for (int n = 0; n < NUM_PLAYERS; n++) begin
      if (alive_next[n]) win_idx = 2'(n);
    end
    end_game = (started_q >= 3'd2) ? (survivors <= 3'd1) : (alive_next == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      started_q      <= '0;
      alive_o        <= '0;
      game_over_o    <= 1'b0;
      winner_valid_o <= 1'b0;
      winner_o       <= '0;
      draw_o         <= 1'b0;
      for (int n = 0; n < NUM_PLAYERS; n++) score_q[n] <= '0;
    end else if (ng_edge) begin
      state_q        <= ST_ARMED;
      alive_o        <= '0;
      game_over_o    <= 1'b0;
      winner_valid_o <= 1'b0;
      winner_o       <= '0;
      draw_o         <= 1'b0;
      for (int n = 0; n < NUM_PLAYERS; n++) score_q[n] <= '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (active_players_i != '0) begin
            alive_o   <= active_players_i;
            started_q <= popcount4(active_players_i);
            state_q   <= ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          // Scoring uses the pre-elimination mask: a player dying on a tick edge still earns it.
          for (int n = 0; n < NUM_PLAYERS; n++) begin
            if (tick && alive_o[n] && score_q[n] != SAT) score_q[n] <= score_q[n] + 1'b1;
          end
          alive_o <= alive_next;
          if (end_game) begin
            state_q     <= ST_OVER;
            game_over_o <= 1'b1;
            if (started_q >= 3'd2) begin
              winner_valid_o <= (survivors == 3'd1);
              winner_o       <= win_idx;
              draw_o         <= (survivors == 3'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) score_o <= '0;
    else       score_o <= score_q[score_sel_i];
  end

endmodule
